pi_seq: RTL and testbench
=========================

PI_SEQ -- requirements
Module: pi_seq

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 go  in  1  start pulse; sampled only in IDLE.
REQ-004 dst  in  16  ALU result, combinational from the ALU this block drives.
REQ-005 src0sel, src1sel  out  3 each  ALU operand selects. src1 codes: 0 ACCUM, 1 ITERM, 2 ERROR_EXT, 3 ERROR_TOP, 4 FWD. src0 codes: 0 A2D_RES, 1 INTGRL_EXT, 2 ICOMP_EXT, 3 PCOMP, 4 PTERM.
REQ-006 multiply, sub, mult2, mult4, saturate  out  1 each  ALU operation controls.
REQ-007 accum  out  16  scratch accumulator register, fed to ALU accum.
REQ-008 pcomp  out  16  proportional term register, fed to ALU pcomp.
REQ-009 intgrl, icomp  out  12 each  integrator and integral-term registers, fed to ALU.
REQ-010 lft, rht  out  12 each  final motor drive results.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 done  out  1  one-cycle pulse on sequence completion.

Function
REQ-013 States SHALL be IDLE, INTG, ICMP1, ICMP2, PCMP1, PCMP2, RHTA, RHT, LFTA, LFT, in that order; each non-IDLE state lasts exactly one cycle, and LFT returns to IDLE.
REQ-014 IDLE->INTG on go=1; go while busy SHALL be ignored and SHALL NOT queue a restart.
REQ-015 ALU controls SHALL be a combinational decode of the state; in IDLE all selects = 0 and all flags = 0.
REQ-016 INTG: src1=3, src0=1, saturate=1; at state exit intgrl <= dst[11:0].
REQ-017 ICMP1/ICMP2: src1=1, src0=1, multiply=1, held both cycles; icomp <= dst[11:0] only at ICMP2 exit (two-cycle multiply path).
REQ-018 PCMP1/PCMP2: src1=2, src0=4, multiply=1, held both cycles; pcomp <= dst only at PCMP2 exit.
REQ-019 RHTA: src1=4, src0=3, sub=1; accum <= dst.
REQ-020 RHT: src1=0, src0=2, sub=1, saturate=1; rht <= dst[11:0].
REQ-021 LFTA: src1=4, src0=3; accum <= dst.
REQ-022 LFT: src1=0, src0=2, saturate=1; lft <= dst[11:0].
REQ-023 mult2 and mult4 SHALL be 0 in every state.
REQ-024 No register SHALL change outside its named capture state; holding registers keep their values between runs.
REQ-025 done SHALL be registered and high for exactly the one cycle after LFT exit, which coincides with the first IDLE cycle; a go sampled in that cycle SHALL be accepted.
REQ-026 Latency: go sampled at edge N gives lft captured at edge N+9 and done high from edge N+9 to N+10.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, busy=0, done=0, and accum, pcomp, intgrl, icomp, lft and rht = 0, including mid-sequence.
REQ-028 After rst deasserts, the block SHALL wait in IDLE for a fresh go.

Configuration
REQ-029 With INTGRL_DECIM_EN defined, a 2-bit counter (reset 0) SHALL increment on each accepted go and wrap 3->0.
REQ-030 With INTGRL_DECIM_EN defined, the intgrl write in INTG SHALL occur only when the counter value is 3 at INTG; INTG still drives its controls and takes its cycle every run.
REQ-031 Without INTGRL_DECIM_EN, no counter SHALL exist and intgrl SHALL update every run.

Verification
REQ-032 Reset, then go pulse with dst driven = 16'h1ABC throughout -> states step in order, busy high for 9 cycles, done one pulse at N+9, intgrl=icomp=lft=rht=12'hABC, pcomp=accum=16'h1ABC.
REQ-033 Per-state dst values 1..9 (one per state) -> intgrl=1, icomp=3, pcomp=5, accum=8, rht=7, lft=9; the value 2 (ICMP1) and 4 (PCMP1) are never captured.
REQ-034 Control check: in PCMP1 -> src1sel=2, src0sel=4, multiply=1; in RHT -> src1sel=0, src0sel=2, sub=1, saturate=1; in IDLE -> all controls 0.
REQ-035 go re-pulsed during PCMP2 -> no restart, single done; go held high through the done cycle -> second run starts immediately.
REQ-036 rst asserted during RHTA -> same-cycle IDLE, all registers 0, no done pulse.
REQ-037 INTGRL_DECIM_EN defined, 4 runs with INTG dst = 10, 20, 30, 40 -> intgrl stays 0 for runs 1-3 and becomes 40 after run 4.

Source files
------------

// File: rtl/pi_seq.sv
// pi_seq: PI controller sequencer driving a shared ALU; optional INTGRL_DECIM_EN decimates integrator writes to every 4th run
module pi_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [15:0] dst,
  output logic [2:0]  src0sel,
  output logic [2:0]  src1sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic [15:0] accum,
  output logic [15:0] pcomp,
  output logic [11:0] intgrl,
  output logic [11:0] icomp,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        busy,
  output logic        done
);
  typedef enum logic [3:0] {IDLE, INTG, ICMP1, ICMP2, PCMP1, PCMP2, RHTA, RHT, LFTA, LFT} state_t;
  state_t r_state, w_next;
  logic [15:0] r_accum, r_pcomp;
  logic [11:0] r_intgrl, r_icomp, r_lft, r_rht;
  logic        r_done;
  logic        w_intg_wr;
`ifdef INTGRL_DECIM_EN
  logic [1:0] r_cnt;
  // run counter: advances once per accepted go (counted as it leaves INTG), so it reads 3 on every 4th run
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= 2'd0;
    else if (r_state == INTG) r_cnt <= r_cnt + 2'd1;
  assign w_intg_wr = (r_cnt == 2'd3);
`else
  assign w_intg_wr = 1'b1;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next-state and ALU control decode; every non-idle state lasts one cycle
  always_comb begin
    w_next   = r_state;
    src1sel  = 3'd0;
    src0sel  = 3'd0;
    multiply = 1'b0;
    sub      = 1'b0;
    saturate = 1'b0;
    case (r_state)
      IDLE:  w_next = go ? INTG : IDLE;
      INTG:  begin w_next = ICMP1; src1sel = 3'd3; src0sel = 3'd1; saturate = 1'b1; end
      ICMP1: begin w_next = ICMP2; src1sel = 3'd1; src0sel = 3'd1; multiply = 1'b1; end
      ICMP2: begin w_next = PCMP1; src1sel = 3'd1; src0sel = 3'd1; multiply = 1'b1; end
      PCMP1: begin w_next = PCMP2; src1sel = 3'd2; src0sel = 3'd4; multiply = 1'b1; end
      PCMP2: begin w_next = RHTA;  src1sel = 3'd2; src0sel = 3'd4; multiply = 1'b1; end
      RHTA:  begin w_next = RHT;   src1sel = 3'd4; src0sel = 3'd3; sub = 1'b1; end
      RHT:   begin w_next = LFTA;  src1sel = 3'd0; src0sel = 3'd2; sub = 1'b1; saturate = 1'b1; end
      LFTA:  begin w_next = LFT;   src1sel = 3'd4; src0sel = 3'd3; end
      LFT:   begin w_next = IDLE;  src1sel = 3'd0; src0sel = 3'd2; saturate = 1'b1; end
      default: w_next = IDLE;
    endcase
  end
  // result capture; multiply results are taken only on the second cycle of their two-cycle path
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_accum  <= 16'd0;
      r_pcomp  <= 16'd0;
      r_intgrl <= 12'd0;
      r_icomp  <= 12'd0;
      r_lft    <= 12'd0;
      r_rht    <= 12'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == LFT);
      case (r_state)
        INTG:  if (w_intg_wr) r_intgrl <= dst[11:0];
        ICMP2: r_icomp <= dst[11:0];
        PCMP2: r_pcomp <= dst;
        RHTA:  r_accum <= dst;
        RHT:   r_rht <= dst[11:0];
        LFTA:  r_accum <= dst;
        LFT:   r_lft <= dst[11:0];
        default: ;
      endcase
    end
  assign mult2  = 1'b0;
  assign mult4  = 1'b0;
  assign accum  = r_accum;
  assign pcomp  = r_pcomp;
  assign intgrl = r_intgrl;
  assign icomp  = r_icomp;
  assign lft    = r_lft;
  assign rht    = r_rht;
  assign done   = r_done;
  assign busy   = (r_state != IDLE);
endmodule

// File: tb/tb_pi_seq.sv
// tb_pi_seq: randomized scoreboard bench for pi_seq against a per-run register model
module tb_pi_seq;
  logic        clk = 0, rst = 1, go = 0;
  logic [15:0] dst = 0;
  logic [2:0]  src0sel, src1sel;
  logic        multiply, sub, mult2, mult4, saturate, busy, done;
  logic [15:0] accum, pcomp;
  logic [11:0] intgrl, icomp, lft, rht;

  pi_seq dut (.clk(clk), .rst(rst), .go(go), .dst(dst), .src0sel(src0sel), .src1sel(src1sel),
    .multiply(multiply), .sub(sub), .mult2(mult2), .mult4(mult4), .saturate(saturate),
    .accum(accum), .pcomp(pcomp), .intgrl(intgrl), .icomp(icomp), .lft(lft), .rht(rht),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] intgrl, icomp, lft, rht;
    logic [15:0] pcomp, accum;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  int          runs;
  int          nvec = 0, nerr = 0;
  logic [15:0] vals[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU controls per step of a run (0 = first cycle after go): {src1, src0, multiply, sub, mult2, mult4, saturate}
  function automatic logic [10:0] ctl_exp(input int k);
    case (k)
      0:       return {3'd3, 3'd1, 5'b00001};
      1, 2:    return {3'd1, 3'd1, 5'b10000};
      3, 4:    return {3'd2, 3'd4, 5'b10000};
      5:       return {3'd4, 3'd3, 5'b01000};
      6:       return {3'd0, 3'd2, 5'b01001};
      7:       return {3'd4, 3'd3, 5'b00000};
      8:       return {3'd0, 3'd2, 5'b00001};
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [10:0] ctl_act();
    return {src1sel, src0sel, multiply, sub, mult2, mult4, saturate};
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    runs = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_regs"}, {accum, pcomp}, 0);
    chk({tag, "_regs12"}, {intgrl, icomp}, 0);
    chk({tag, "_lr"}, {lft, rht}, 0);
  endtask

  // one run: vals[k] is driven during step k; abort_at >= 0 asserts rst in that step
  task automatic run(input bit chain, input int abort_at);
    exp_t e;
    @(negedge clk);
    go = 1;
    e = m;
`ifdef INTGRL_DECIM_EN
    if (runs % 4 == 3) e.intgrl = vals[0][11:0];
`else
    e.intgrl = vals[0][11:0];
`endif
    runs++;
    e.icomp = vals[2][11:0];
    e.pcomp = vals[4];
    e.rht   = vals[6][11:0];
    e.accum = vals[7];
    e.lft   = vals[8][11:0];
    @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      go  = (k == 8) ? chain : 1'($urandom_range(0, 1));
      dst = vals[k];
      chk("busy_run", 32'(busy), 1);
      chk("ctl_run", 32'(ctl_act()), 32'(ctl_exp(k)));
      if (k == abort_at) begin
        rst = 1;
        go  = 0;
        #1;
        check_zero("rst_mid");
        sb.delete();
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("rst_hold");
        rst = 0;
        repeat (3) @(negedge clk);
        chk("rst_wait_busy", 32'(busy), 0);
        return;
      end
    end
    m = e;
    sb.push_back(e);
    if (!chain) begin
      @(negedge clk);
      go = 0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ctl", 32'(ctl_act()), 0);
      chk("sb_drained", 32'(sb.size()), 0);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding run
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_done", 32'(done), 0);
        else begin
          e = sb.pop_front();
          chk("intgrl", 32'(intgrl), 32'(e.intgrl));
          chk("icomp", 32'(icomp), 32'(e.icomp));
          chk("pcomp", 32'(pcomp), 32'(e.pcomp));
          chk("accum", 32'(accum), 32'(e.accum));
          chk("rht", 32'(rht), 32'(e.rht));
          chk("lft", 32'(lft), 32'(e.lft));
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    chk("reset_ctl", 32'(ctl_act()), 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("idle_wait", 32'(busy), 0);
    for (int k = 0; k < 9; k++) vals[k] = 16'h1ABC;
    run(0, -1);
    for (int k = 0; k < 9; k++) vals[k] = 16'(k + 1);
    run(0, -1);
    for (int k = 0; k < 9; k++) vals[k] = 16'($urandom);
    run(1, -1);
    for (int k = 0; k < 9; k++) vals[k] = 16'($urandom);
    run(0, -1);
    for (int k = 0; k < 9; k++) vals[k] = 16'($urandom);
    run(0, 5);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 9; k++) vals[k] = 16'($urandom);
      vals[0] = 16'(10 * (r + 1));
      run(0, -1);
    end
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 9; k++) vals[k] = 16'($urandom);
      run(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1);
    end
    @(negedge clk);
    go = 0;
    repeat (3) @(negedge clk);
    chk("final_drain", 32'(sb.size()), 0);
    chk("final_busy", 32'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
